// File: rtl/amds_rx_sequencer.sv
// Acquisition sequencer for AMDS receivers: sync pulse, programmable delay,
// receiver start, watchdog-guarded completion wait and cycle statistics.
module amds_rx_sequencer #(
   parameter int NUM_RX   = 2,
   parameter int SYNC_LEN = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic [15:0]           cfg_delay,
   input  logic [15:0]           cfg_timeout,
   input  logic [NUM_RX-1:0]     rx_done,
   input  logic [4*NUM_RX-1:0]   rx_valid,
   output logic                  sync_adc,
   output logic [NUM_RX-1:0]     start_rx,
   output logic                  busy,
   output logic                  all_done,
   output logic                  timeout_flag,
   output logic [4*NUM_RX-1:0]   valid_latched,
   output logic [15:0]           counter_cycles,
   output logic [15:0]           counter_timeouts,
   output logic [15:0]           counter_missed
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      DELAY = 3'd2,
      START = 3'd3,
      WAIT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [15:0] SYNC_LAST = 16'(SYNC_LEN - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] delay_sh;
   logic [15:0] timeout_sh;
   logic        rx_all_done;
   logic        wd_expired;

   assign rx_all_done = &rx_done;
   // cnt runs 0..timeout-1 in WAIT, so WAIT lasts exactly timeout cycles
   assign wd_expired  = (timeout_sh != 16'd0) && (cnt == timeout_sh - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= 16'd0;
         delay_sh         <= 16'd0;
         timeout_sh       <= 16'd0;
         sync_adc         <= 1'b0;
         start_rx         <= '0;
         busy             <= 1'b0;
         all_done         <= 1'b0;
         timeout_flag     <= 1'b0;
         valid_latched    <= '0;
         counter_cycles   <= 16'd0;
         counter_timeouts <= 16'd0;
         counter_missed   <= 16'd0;
      end else begin
         if (trigger && (state != IDLE))
            counter_missed <= counter_missed + 16'd1;

         case (state)
            IDLE: begin
               if (trigger && enable) begin
                  state      <= SYNC;
                  sync_adc   <= 1'b1;
                  busy       <= 1'b1;
                  cnt        <= 16'd0;
                  delay_sh   <= cfg_delay;
                  timeout_sh <= cfg_timeout;
               end
            end
            SYNC: begin
               if (cnt == SYNC_LAST) begin
                  sync_adc <= 1'b0;
                  cnt      <= 16'd0;
                  if (delay_sh == 16'd0) begin
                     state    <= START;
                     start_rx <= '1;
                  end else begin
                     state <= DELAY;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DELAY: begin
               if (cnt == delay_sh - 16'd1) begin
                  state    <= START;
                  start_rx <= '1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            START: begin
               start_rx <= '0;
               state    <= WAIT;
               cnt      <= 16'd0;
            end
            WAIT: begin
               // completion on the expiry cycle wins over the watchdog
               if (rx_all_done || wd_expired) begin
                  state          <= DONE;
                  all_done       <= 1'b1;
                  valid_latched  <= rx_valid;
                  timeout_flag   <= ~rx_all_done;
                  counter_cycles <= counter_cycles + 16'd1;
                  if (!rx_all_done)
                     counter_timeouts <= counter_timeouts + 16'd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE: begin
               all_done <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state    <= IDLE;
               sync_adc <= 1'b0;
               start_rx <= '0;
               busy     <= 1'b0;
               all_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/amds_rx_sequencer.md
AMDS_RX_SEQUENCER -- requirements
Module: amds_rx_sequencer

Interface
REQ-001 Parameter: NUM_RX, default 2, number of AMDS data lines and receiver instances sequenced.
REQ-002 Parameter: SYNC_LEN, default 8, width of the AMDS conversion-sync pulse in clk cycles (minimum 1).
REQ-003 Ports, in order:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  sequencer enable; triggers are accepted only while high.
- trigger  in  1  one-cycle pulse requesting one acquisition cycle (e.g. PWM carrier peak).
- cfg_delay  in  16  cycles from sync-pulse end to start_rx.
- cfg_timeout  in  16  watchdog cycles allowed in WAIT; 0 disables the watchdog.
- rx_done  in  NUM_RX  per-receiver done level; cleared by the receiver on its start_rx and held high until the next start.
- rx_valid  in  4*NUM_RX  per-receiver word-valid flags; bits [4i+3:4i] belong to receiver i.
- sync_adc  out  1  conversion-sync pulse to the AMDS.
- start_rx  out  NUM_RX  one-cycle start pulse to each receiver.
- busy  out  1  high in any state other than IDLE.
- all_done  out  1  one-cycle pulse at cycle completion.
- timeout_flag  out  1  1 if the last cycle ended by watchdog.
- valid_latched  out  4*NUM_RX  rx_valid snapshot from the last completed cycle.
- counter_cycles  out  16  completed cycles.
- counter_timeouts  out  16  watchdog expirations.
- counter_missed  out  16  triggers rejected because the sequencer was busy.

Function
REQ-004 The state machine SHALL have states IDLE, SYNC, DELAY, START, WAIT and DONE.
REQ-005 IDLE: on trigger & enable, next state SHALL be SYNC; cfg_delay and cfg_timeout SHALL be captured into shadow registers in the same edge, and later config changes SHALL NOT affect the cycle in progress.
REQ-006 trigger while not in IDLE SHALL NOT be acted on and SHALL increment counter_missed. trigger in IDLE with enable low SHALL be ignored without counting.
REQ-007 SYNC: sync_adc SHALL be high for exactly SYNC_LEN cycles, starting the cycle after trigger acceptance; next state SHALL then be DELAY.
REQ-008 DELAY: the block SHALL remain in DELAY for exactly shadow cfg_delay cycles, then go to START. With cfg_delay = 0, DELAY SHALL last 0 cycles and START SHALL directly follow SYNC.
REQ-009 START: all start_rx bits SHALL be high for exactly one cycle; next state SHALL be WAIT and the wait counter SHALL clear.
REQ-010 WAIT: when &rx_done == 1, next state SHALL be DONE.
REQ-011 WAIT watchdog: if shadow timeout != 0 and the wait counter reaches shadow timeout with rx_done not all high, next state SHALL be DONE with timeout set. If rx_done completes in the same cycle as expiry, that SHALL count as success, not timeout.
REQ-012 DONE, for exactly one cycle:
- all_done SHALL be 1.
- valid_latched SHALL load rx_valid.
- timeout_flag SHALL load the timeout condition.
- counter_cycles SHALL increment.
- counter_timeouts SHALL increment if the cycle timed out.
- next state SHALL be IDLE.
REQ-013 A trigger arriving during the DONE cycle SHALL be counted as missed.
REQ-014 Deasserting enable mid-cycle SHALL NOT abort the cycle; the cycle SHALL complete normally.
REQ-015 Latency, trigger edge to start_rx: SYNC_LEN + cfg_delay + 1 cycles.
REQ-016 All counters SHALL be 16-bit unsigned, wrap 0xFFFF->0x0000, and increment at most once per cycle.
REQ-017 Unused or illegal state encodings SHALL transition to IDLE with no outputs asserted.

Reset
REQ-018 While rst_n is low, the block SHALL be in IDLE and every output SHALL be 0: sync_adc, start_rx, busy, all_done, timeout_flag, valid_latched and all three counters.
REQ-019 rst_n assertion mid-cycle SHALL abort immediately with no all_done pulse; after release the block SHALL accept the next trigger normally.

Verification
REQ-020 Nominal: SYNC_LEN=8, cfg_delay=5, cfg_timeout=100, both rx_done rise 20 cycles into WAIT, rx_valid=8'hFF -> sync_adc high 8 cycles, start_rx=2'b11 at trigger+14, all_done once, valid_latched=8'hFF, counter_cycles=1, timeout_flag=0.
REQ-021 Watchdog: cfg_timeout=50, rx_done[1] never rises, rx_valid=8'h0F -> DONE after 50 WAIT cycles, timeout_flag=1, counter_timeouts=1, valid_latched=8'h0F.
REQ-022 Missed triggers: 3 triggers during SYNC/WAIT plus 1 in the DONE cycle -> counter_missed=4, exactly one start_rx pulse.
REQ-023 Config shadowing and zero delay: cfg_delay=0, and cfg_delay changes to 200 during SYNC -> start_rx at trigger+SYNC_LEN+1; cfg_timeout=0 with rx_done held low -> stays in WAIT indefinitely, busy=1.
REQ-024 Boundary and reset: counter_cycles preset to 0xFFFF by 65535 cycles, then one more -> 0x0000. Reset asserted in WAIT -> all outputs 0 at once, no all_done, next trigger sequences normally.
